sram_arbiter: RTL
=================

# sram_arbiter

Two-requester arbiter that shares the single-port synchronous SRAM between the instruction-fetch path and the load/store path of the CPU. One SRAM access per cycle. Each requester gets a req/gnt handshake and a registered read-return (`*_rvalid`, `*_rdata`). The block sits between the core front-end/LSU and the SRAM's `CS`/`WE`/`addr`/`data_in`/`data_out` pins.

## Interface
Parameters:
- `ADDR`, 8: SRAM address width.
- `WIDTH`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch read request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` valid this cycle (one-cycle pulse).
- `if_rdata`  out  WIDTH  fetch read data (registered, held until next fetch return).
- `ls_req`  in  1  load/store request; held with `ls_we`/`ls_addr`/`ls_wdata` stable until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  ADDR  load/store address.
- `ls_wdata`  in  WIDTH  store data.
- `ls_gnt`  out  1  load/store request accepted this cycle (combinational).
- `ls_rvalid`  out  1  `ls_rdata` valid this cycle (loads only).
- `ls_rdata`  out  WIDTH  load data (registered, held).
- `CS`  out  1  SRAM chip select.
- `WE`  out  1  SRAM write enable.
- `addr`  out  ADDR  SRAM address.
- `data_in`  out  WIDTH  SRAM write data.
- `data_out`  in  WIDTH  SRAM registered read data (valid the cycle after a read edge).

## Operation
- State:
  - `prio`: 1 bit; 0 = fetch favoured, 1 = load/store favoured.
  - `pend_v`, `pend_id`: outstanding read tracking.
  - `if_rdata`/`ls_rdata`, `if_rvalid`/`ls_rvalid`: registered outputs.
- Arbitration (combinational, per cycle):
  - Only one requester asserts → it wins.
  - Both assert → `prio` selects the winner.
  - Neither asserts → `CS`=0 and both gnts are 0.
- Winner drive:
  - Winner's gnt=1 and `CS`=1.
  - `addr` = winner address.
  - `WE` = `ls_we` if load/store wins, else 0.
  - `data_in` = `ls_wdata`. Don't-care when `WE`=0; drive `ls_wdata` unconditionally.
- `prio` update on each grant: set to favour the loser (round-robin, see Configuration). Unchanged when no grant.
- Read tracking:
  - On a read grant: `pend_v`←1 and `pend_id`←winner (0 = fetch, 1 = ls).
  - Otherwise `pend_v`←0.
- Read return: in the cycle with `pend_v`=1, `data_out` is captured at that cycle's posedge into `<pend_id>_rdata`, and `<pend_id>_rvalid` pulses for the following cycle.
- Store: no return, no rvalid.
- Back-to-back grants are allowed every cycle; reads and writes may interleave freely.

## Timing
- Grant cycle T:
  - SRAM samples at posedge ending T.
  - `data_out` is valid during T+1.
  - `*_rdata`/`*_rvalid` are valid during T+2.
  - Read latency req→rvalid = 2 cycles when uncontended.
- Store at T followed by a load of the same address at T+1: the load returns the stored value.
- Ties:
  - A same-cycle store and fetch are never both granted; the loser retries the next cycle.
  - Loser waits ≤1 cycle under round-robin.
- Reset (async, any time, including with a read pending):
  - `prio`=0, `pend_v`=0.
  - `if_rvalid`=`ls_rvalid`=0, `if_rdata`=`ls_rdata`=0.
  - During reset `CS`, `WE`, `if_gnt`, `ls_gnt` are forced to 0.
  - A pending read is discarded; no rvalid is produced after reset release.
- Requester dropping req before gnt is legal; no access occurs.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin. After a grant, `prio` points to the other requester.
- Undefined: fixed priority.
  - load/store always wins ties; `prio` is held at 1.
  - Fetch can starve under continuous `ls_req`.
  - All other behaviour is identical.

## Test plan
- Reset mid-read: `if_req`, `if_addr`=0x05 granted at T; `rst` pulsed during T+1 → no `if_rvalid`, `if_rdata`=0, `CS`=0 during reset.
- Single fetch: mem[0x10]=0xDEADBEEF, `if_req` with `if_addr`=0x10 → `if_gnt` same cycle, `if_rvalid`=1 with `if_rdata`=0xDEADBEEF two cycles later, `ls_rvalid` stays 0.
- Store then load: store 0x12345678 to 0x20, load 0x20 the next cycle → `ls_rdata`=0x12345678; `if_rdata` unchanged.
- Contention, RR on: `if_req` and `ls_req` held high 4 cycles from reset → grants alternate if, ls, if, ls; each read's rvalid is routed to the correct requester.
- Contention, RR off: same stimulus → `ls_gnt` every cycle, `if_gnt`=0 until `ls_req` drops, then fetch is granted next cycle.
- Idle/drop: `if_req` pulses for 1 cycle while `ls_req` wins → no fetch access, no `if_rvalid`; `CS`=0 in cycles with no req.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles the fetch requester, load/store requester and
// SRAM pin groups of the SRAM arbiter. The arbiter attaches through the
// slave modport; the requesters and the SRAM macro sit on the master side.
interface sram_arbiter_if #(
  parameter int ADDR  = 8,
  parameter int WIDTH = 32
);
  // instruction-fetch requester
  logic             if_req;
  logic [ADDR-1:0]  if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  // load/store requester
  logic             ls_req;
  logic             ls_we;
  logic [ADDR-1:0]  ls_addr;
  logic [WIDTH-1:0] ls_wdata;
  logic             ls_gnt;
  logic             ls_rvalid;
  logic [WIDTH-1:0] ls_rdata;
  // SRAM pins
  logic             CS;
  logic             WE;
  logic [ADDR-1:0]  addr;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, data_out,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output CS, WE, addr, data_in
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, data_out,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  CS, WE, addr, data_in
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch path and the load/store path, one access per cycle,
// with registered read returns routed back to the requester that issued
// the read.
// Build option: define SRAM_ARB_RR_EN for round-robin tie breaking;
// otherwise load/store always wins ties (fixed priority, prio held at 1).
module sram_arbiter #(
  parameter int ADDR  = 8,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  logic             prio;       // 0 = fetch favoured, 1 = load/store favoured
  logic             pend_v;     // a read was issued to the SRAM last cycle
  src_e             pend_id;    // which requester owns that read
  logic             if_win;
  logic             ls_win;
  logic             rd_grant;
  logic [ADDR-1:0]  sel_addr;
  logic             if_rvalid_q;
  logic             ls_rvalid_q;
  logic [WIDTH-1:0] if_rdata_q;
  logic [WIDTH-1:0] ls_rdata_q;

`ifdef SRAM_ARB_RR_EN
  // Round-robin: after any grant, favour the requester that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (if_win || ls_win) begin
      prio <= if_win;
    end
  end
`else
  // Fixed priority: load/store permanently favoured.
  assign prio = 1'b1;
`endif

  // Arbitration: a sole requester wins, ties go to prio; nothing granted in reset.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!rst) begin
      if_win = bus.if_req && (!bus.ls_req || !prio);
      ls_win = bus.ls_req && (!bus.if_req || prio);
    end
  end

  assign rd_grant = if_win || (ls_win && !bus.ls_we);

  // SRAM drive and grant outputs from the arbitration result.
  always_comb begin
    sel_addr    = ls_win ? bus.ls_addr : bus.if_addr;
    bus.if_gnt  = if_win;
    bus.ls_gnt  = ls_win;
    bus.CS      = if_win || ls_win;
    bus.WE      = ls_win && bus.ls_we;
    bus.addr    = sel_addr;
    bus.data_in = bus.ls_wdata;
  end

  // Outstanding-read tracking: remembers the owner of the read just issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v  <= 1'b0;
      pend_id <= SRC_IF;
    end else begin
      pend_v  <= rd_grant;
      if (rd_grant) begin
        pend_id <= ls_win ? SRC_LS : SRC_IF;
      end
    end
  end

  // Read return: capture SRAM data into the owner's holding register and pulse its rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= pend_v && (pend_id == SRC_IF);
      ls_rvalid_q <= pend_v && (pend_id == SRC_LS);
      if (pend_v && (pend_id == SRC_IF)) begin
        if_rdata_q <= bus.data_out;
      end
      if (pend_v && (pend_id == SRC_LS)) begin
        ls_rdata_q <= bus.data_out;
      end
    end
  end

  // Registered return outputs onto the interface.
  always_comb begin
    bus.if_rvalid = if_rvalid_q;
    bus.ls_rvalid = ls_rvalid_q;
    bus.if_rdata  = if_rdata_q;
    bus.ls_rdata  = ls_rdata_q;
  end

endmodule
